// File: rtl/gray_step_checker_if.sv
// rtl/gray_step_checker_if.sv - sample and status bus of the Gray step checker
interface gray_step_checker_if #(
  parameter int W  = 3,
  parameter int CW = 8
);
  logic          valid;
  logic [W-1:0]  gray;
  logic          clear;
  logic [W-1:0]  binary;
  logic          step;
  logic          wrap;
  logic [CW-1:0] wrap_cnt;
  logic          error;
  logic [1:0]    err_code;

  // Upstream side: drives samples and control, observes status
  modport master (
    output valid, gray, clear,
    input  binary, step, wrap, wrap_cnt, error, err_code
  );

  // Checker side
  modport slave (
    input  valid, gray, clear,
    output binary, step, wrap, wrap_cnt, error, err_code
  );
endinterface

// File: rtl/gray_step_checker.sv
// rtl/gray_step_checker.sv - Gray counter monitor: single forward step check, wrap count, sticky fault
module gray_step_checker #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gray_step_checker_if.slave mon
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_BACK = 2'b01;
  localparam logic [1:0] ERR_JUMP = 2'b10;

  state_t        state_q, state_d;
  // binary_q doubles as the previous-sample reference: both are only ever
  // loaded together with the same accepted value.
  logic [W-1:0]  binary_q, binary_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic          error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;

  logic [W-1:0]  bin_in;
  logic [W-1:0]  delta;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_in = gray2bin(mon.gray);
  // Modular distance from the reference; +1 is the only legal advance
  assign delta  = bin_in - binary_q;

  // Next-state and output decode; Clear overrides everything
  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    error_d    = error_q;
    err_code_d = err_code_q;

    if (mon.clear) begin
      state_d    = IDLE;
      error_d    = 1'b0;
      err_code_d = ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mon.valid) begin
            binary_d = bin_in;
            state_d  = TRACK;
          end
        end
        TRACK: begin
          if (mon.valid) begin
            if (delta == W'(0)) begin
              // Upstream stalled; repeated value is legal
            end else if (delta == W'(1)) begin
              step_d   = 1'b1;
              binary_d = bin_in;
              if (binary_q == {W{1'b1}}) begin
                wrap_d = 1'b1;
                if (wrap_cnt_q != {CW{1'b1}}) begin
                  wrap_cnt_d = wrap_cnt_q + CW'(1);
                end
              end
            end else if (delta == {W{1'b1}}) begin
              error_d    = 1'b1;
              err_code_d = ERR_BACK;
              state_d    = FAULT;
            end else begin
              error_d    = 1'b1;
              err_code_d = ERR_JUMP;
              state_d    = FAULT;
            end
          end
        end
        FAULT: begin
          // Sticky until Clear or reset
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      binary_q   <= '0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign mon.binary   = binary_q;
  assign mon.step     = step_q;
  assign mon.wrap     = wrap_q;
  assign mon.wrap_cnt = wrap_cnt_q;
  assign mon.error    = error_q;
  assign mon.err_code = err_code_q;

endmodule

// File: tb/tb_gray_step_checker.sv
// tb/tb_gray_step_checker.sv - directed self-checking bench for gray_step_checker
module tb_gray_step_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  gray_step_checker_if #(.W(3), .CW(8)) bus1 ();
  gray_step_checker_if #(.W(3), .CW(2)) bus2 ();

  gray_step_checker #(.W(3), .CW(8)) dut1 (.clk_i(clk), .rst_i(rst), .mon(bus1));
  gray_step_checker #(.W(3), .CW(2)) dut2 (.clk_i(clk), .rst_i(rst), .mon(bus2));

  always #5 clk = ~clk;

  // Gray codes of binary 0..7, written out by hand
  logic [2:0] gtab [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};
  logic [7:0] cnt_exp [0:3] = '{8'd1, 8'd2, 8'd3, 8'd3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [2:0] g, input logic c);
    bus1.valid = v;
    bus1.gray  = g;
    bus1.clear = c;
    tick();
  endtask

  task automatic drive2(input logic v, input logic [2:0] g, input logic c);
    bus2.valid = v;
    bus2.gray  = g;
    bus2.clear = c;
    tick();
  endtask

  task automatic check1(input string tag, input logic [2:0] b, input logic s,
                        input logic w, input logic e, input logic [1:0] ec);
    check_eq({tag, ".binary"},   32'(bus1.binary),   32'(b));
    check_eq({tag, ".step"},     32'(bus1.step),     32'(s));
    check_eq({tag, ".wrap"},     32'(bus1.wrap),     32'(w));
    check_eq({tag, ".error"},    32'(bus1.error),    32'(e));
    check_eq({tag, ".err_code"}, 32'(bus1.err_code), 32'(ec));
  endtask

  initial begin
    bus1.valid = 1'b0; bus1.gray = 3'b000; bus1.clear = 1'b0;
    bus2.valid = 1'b0; bus2.gray = 3'b000; bus2.clear = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check1("reset", 3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_eq("reset.wrap_cnt", 32'(bus1.wrap_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Full legal lap: 000 is the reference, then 8 advances ending in a wrap
    for (int i = 0; i < 9; i++) begin
      drive1(1'b1, gtab[i % 8], 1'b0);
      check1($sformatf("lap%0d", i), 3'(i % 8), (i > 0), (i == 8), 1'b0, 2'b00);
    end
    check_eq("lap.wrap_cnt", 32'(bus1.wrap_cnt), 32'd1);

    // Backward step from bin 2 to bin 1
    drive1(1'b1, 3'b001, 1'b0);
    drive1(1'b1, 3'b011, 1'b0);
    check1("to2", 3'd2, 1'b1, 1'b0, 1'b0, 2'b00);
    drive1(1'b1, 3'b001, 1'b0);
    check1("back", 3'd2, 1'b0, 1'b0, 1'b1, 2'b01);
    drive1(1'b1, 3'b010, 1'b0);
    check1("back_ign", 3'd2, 1'b0, 1'b0, 1'b1, 2'b01);
    drive1(1'b0, 3'b000, 1'b1);
    check1("back_clr", 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);

    // Jump from bin 1 to bin 4
    drive1(1'b1, 3'b001, 1'b0);
    check1("jref", 3'd1, 1'b0, 1'b0, 1'b0, 2'b00);
    drive1(1'b1, 3'b110, 1'b0);
    check1("jump", 3'd1, 1'b0, 1'b0, 1'b1, 2'b10);
    drive1(1'b1, 3'b010, 1'b0);
    check1("jump_ign", 3'd1, 1'b0, 1'b0, 1'b1, 2'b10);
    drive1(1'b0, 3'b000, 1'b1);
    check1("jump_clr", 3'd1, 1'b0, 1'b0, 1'b0, 2'b00);

    // Repeated samples and Valid low are both silent
    drive1(1'b1, 3'b011, 1'b0);
    check1("href", 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, 3'b011, 1'b0);
      check1($sformatf("hold%0d", i), 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
    end
    for (int i = 0; i < 5; i++) begin
      drive1(1'b0, 3'($urandom_range(0, 7)), 1'b0);
      check1($sformatf("noval%0d", i), 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
    end

    // Clear beats a legal advance; the next sample is only a reference
    drive1(1'b1, 3'b010, 1'b1);
    check1("clrpri", 3'd2, 1'b0, 1'b0, 1'b0, 2'b00);
    drive1(1'b1, 3'b010, 1'b0);
    check1("clrref", 3'd3, 1'b0, 1'b0, 1'b0, 2'b00);
    check_eq("clr.wrap_cnt", 32'(bus1.wrap_cnt), 32'd1);
    bus1.valid = 1'b0;

    // Two-bit wrap counter saturates at 3 while Wrap keeps pulsing
    drive2(1'b1, 3'b000, 1'b0);
    check_eq("sat.ref_step", 32'(bus2.step), 32'd0);
    for (int w = 0; w < 4; w++) begin
      for (int k = 1; k <= 8; k++) begin
        drive2(1'b1, gtab[k % 8], 1'b0);
        if (k == 8) begin
          check_eq($sformatf("sat%0d.wrap", w), 32'(bus2.wrap), 32'd1);
          check_eq($sformatf("sat%0d.cnt", w), 32'(bus2.wrap_cnt), 32'(cnt_exp[w][1:0]));
          check_eq($sformatf("sat%0d.step", w), 32'(bus2.step), 32'd1);
        end
      end
    end
    drive2(1'b1, 3'b110, 1'b0);
    check_eq("flt.error", 32'(bus2.error), 32'd1);
    check_eq("flt.code", 32'(bus2.err_code), 32'd2);
    check_eq("flt.cnt", 32'(bus2.wrap_cnt), 32'd3);

    // Asynchronous reset in the middle of a cycle while faulted
    #2;
    rst = 1'b1;
    #1;
    check_eq("areset.error", 32'(bus2.error), 32'd0);
    check_eq("areset.code", 32'(bus2.err_code), 32'd0);
    check_eq("areset.cnt", 32'(bus2.wrap_cnt), 32'd0);
    check_eq("areset.binary", 32'(bus2.binary), 32'd0);
    check_eq("areset.wrap", 32'(bus2.wrap), 32'd0);
    check_eq("areset.step", 32'(bus2.step), 32'd0);
    check_eq("areset.dut1_cnt", 32'(bus1.wrap_cnt), 32'd0);
    tick();
    rst = 1'b0;
    drive2(1'b1, 3'b001, 1'b0);
    check_eq("post.ref_binary", 32'(bus2.binary), 32'd1);
    check_eq("post.ref_step", 32'(bus2.step), 32'd0);
    drive2(1'b1, 3'b011, 1'b0);
    check_eq("post.binary", 32'(bus2.binary), 32'd2);
    check_eq("post.step", 32'(bus2.step), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_step_checker.md
Name: gray_step_checker

Overview:
- Downstream consumer of the 3-bit Gray counter stage.
- Samples the Gray code each cycle and converts it to binary.
- Verifies that every change is a legal single forward step, and counts wrap-arounds (111-binary -> 000-binary).
- Latches a sticky fault with a cause code on any illegal transition. Used as the on-chip monitor for the counter's Output bus.

Parameters:
- W, 3, width of the Gray input and binary output.
- CW, 8, width of the saturating wrap counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Valid  input  1  Gray sample qualifier; the sample is ignored when low.
- Gray  input  W  Gray-coded value from the upstream counter.
- Clear  input  1  synchronous restart to IDLE; keeps WrapCnt.
- Binary  output  W  binary of the last accepted Gray sample (registered).
- Step  output  1  one-cycle pulse on a legal +1 advance.
- Wrap  output  1  one-cycle pulse on a legal advance from 2^W-1 to 0.
- WrapCnt  output  CW  number of wraps seen, saturating at all-ones.
- Error  output  1  sticky fault flag.
- ErrCode  output  2  00 none, 01 backward step, 10 multi-step or illegal jump.

Behaviour:
- Reset (asynchronous, any time) sets:
  - state to IDLE
  - Binary=0, Step=0, Wrap=0
  - WrapCnt=0
  - Error=0, ErrCode=00
  - internal prev register=0
- Conversion:
  - bin[W-1] = g[W-1]
  - bin[i] = bin[i+1] XOR g[i]
  - Combinational on the input; only the registered result is visible.
- Latency: every output reflects the sample taken on the previous rising edge, i.e. 1 cycle.
- Step and Wrap default to 0 every cycle unless set by a legal advance in that cycle.
- States: IDLE, TRACK, FAULT.
- IDLE:
  - Valid=1: prev <= bin(Gray), Binary <= bin(Gray), go to TRACK. No Step and no check; the first sample is accepted as the reference.
  - Valid=0: stay.
- TRACK, Valid=0: hold all state.
- TRACK, Valid=1, computed on d = bin(Gray) - prev mod 2^W:
  - d=0: hold. No pulse and no error; repeated samples are legal because upstream En may be low.
  - d=1: Step=1, prev and Binary <= bin(Gray).
    - If prev was 2^W-1: Wrap=1, and WrapCnt <= WrapCnt+1 unless already all-ones.
  - d=2^W-1: Error=1, ErrCode=01, go to FAULT. Binary and prev are not updated.
  - Any other d: Error=1, ErrCode=10, go to FAULT. Binary and prev are not updated.
- FAULT:
  - Inputs are ignored.
  - Error and ErrCode hold.
  - Step=0 and Wrap=0.
- Clear=1 in any state:
  - Next state is IDLE; Error=0, ErrCode=00, Step=0, Wrap=0.
  - Binary and WrapCnt hold.
  - Clear has priority over Valid in the same cycle; that sample is discarded.
- Simultaneous events:
  - A wrap and a saturated counter in the same cycle: Wrap pulses and WrapCnt stays all-ones.
  - An error cycle never asserts Step or Wrap.
- Reset mid-operation, including during FAULT, clears everything immediately without waiting for a clock edge.

Test Plan:
- Reset, then Valid=1 with Gray = 000,001,011,010,110,111,101,100,000 on successive cycles:
  - Binary follows 0..7 then 0, one cycle late.
  - Step=1 on the last 8 samples.
  - Wrap=1 once, on the 100->000 sample; WrapCnt=1; Error=0.
- TRACK at Gray=011 (bin 2), then Valid=1 with Gray=001 (bin 1):
  - Next cycle Error=1, ErrCode=01, Binary stays 2.
  - Further samples are ignored.
  - Clear=1 returns to IDLE with Error=0.
- TRACK at Gray=001, then Gray=110 (bin 4):
  - Error=1, ErrCode=10, Step=0.
  - Gray=010 afterwards causes no change while in FAULT.
- Same Gray held with Valid=1 for 5 cycles, then Valid=0 with random Gray:
  - No Step, no Error, Binary unchanged.
- CW=2, run 4 full cycles of legal wraps:
  - WrapCnt goes 1,2,3,3.
  - The 4th wrap still pulses Wrap.
- Assert Reset asynchronously mid-cycle while in FAULT with WrapCnt=3:
  - All outputs go to 0 before the next Clk edge.
  - The first Valid afterwards is a reference only, with no Step.
